synapse_mem: RTL
================

SYNAPSE_MEM -- requirements
Module: synapse_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; depth is 2^ADDR_W.
REQ-002 SHALL have parameter DW, default 8, word width; words are two's-complement signed.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rd_en  input  1  read request.
REQ-007 rd_addr  input  ADDR_W  read address.
REQ-008 rd_data  output  DW  registered read data.
REQ-009 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-010 upd_valid  input  1  update request.
REQ-011 upd_ready  output  1  update accepted when upd_valid and upd_ready are both high at a clk edge.
REQ-012 upd_mode  input  1  0 = overwrite with upd_data; 1 = saturating accumulate of upd_data.
REQ-013 upd_addr  input  ADDR_W  update address.
REQ-014 upd_data  input  DW  write value or signed delta.
REQ-015 busy  output  1  clear sequence in progress.
REQ-016 sat  output  1  one-cycle pulse: the committed accumulate was clamped.

Function
REQ-017 SHALL perform a read on edge E when rd_en=1 and busy=0: rd_data<=mem[rd_addr], rd_valid<=1; otherwise rd_valid<=0 and rd_data holds its value.
REQ-018 SHALL process an update in two stages: at the accept edge E0, capture addr, mode and data, and capture the old word; at E0+1, write the result to the memory.
REQ-019 SHALL compute the accumulate result as old+delta in DW+1 bits, clamped to the range [-2^(DW-1), 2^(DW-1)-1]; sat<=1 at the commit edge when clamping occurs, else 0.
REQ-020 SHALL, in overwrite mode, commit upd_data unchanged and set sat<=0.
REQ-021 SHALL hold upd_ready=1 whenever busy=0, sustaining one update per cycle with no bubbles.
REQ-022 SHALL forward the in-flight result when an update is accepted at the same edge as a commit to the same address; the new update's old word SHALL be the committing result, not the stale memory word.
REQ-023 SHALL return the pre-commit value (read-first) when a read and a commit target the same address at the same edge.
REQ-024 SHALL allow reads and updates in the same cycle without mutual stalls.
REQ-025 SHALL wrap address arithmetic of the clear counter from 2^ADDR_W-1 to 0 only at sequence end; no other address arithmetic exists.

Reset
REQ-026 SHALL drive the following values asynchronously on rst_n=0: rd_data=0, rd_valid=0, sat=0, stage-1 valid=0.
REQ-027 SHALL discard any in-flight update when reset asserts mid-operation; the discarded update is never committed.
REQ-028 SHALL not reset memory contents, except through REQ-030.

Configuration
REQ-029 SHALL gate a power-on clear FSM with macro SYNAPSE_MEM_CLEAR_EN.
REQ-030 With SYNAPSE_MEM_CLEAR_EN defined, the clear FSM SHALL behave as follows:
- States: CLEAR, IDLE. Reset enters CLEAR with the counter at 0 and busy=1.
- CLEAR writes 0 to mem[counter] each cycle.
- After the 2^ADDR_W-th write, the FSM enters IDLE and busy=0.
- During CLEAR: upd_ready=0, rd_en is ignored, rd_valid=0.
- Reset asserted mid-clear restarts the clear at address 0.
REQ-031 Without SYNAPSE_MEM_CLEAR_EN: no FSM is built, busy is tied to 0, upd_ready=1 from the first edge after reset, and memory contents are undefined until written.

Verification
REQ-032 Overwrite addr 3 with 0x05, then read addr 3 -> rd_data=0x05 with rd_valid=1 one cycle after the rd_en edge.
REQ-033 Write 0x7E to addr 1, then accumulate +5 -> committed word 0x7F, sat=1; write 0x82, accumulate -5 -> 0x80, sat=1.
REQ-034 Write 0 to addr 2, then three back-to-back accumulates of +1 to addr 2 -> final word 3, confirming forwarding.
REQ-035 Read addr 4 at the same edge as a commit of 0x11 to addr 4 (old 0x22) -> rd_data=0x22; the next read returns 0x11.
REQ-036 With SYNAPSE_MEM_CLEAR_EN and ADDR_W=4: busy is high for exactly 16 cycles after reset, all words then read 0, and upd_ready=0 throughout CLEAR.
REQ-037 Assert reset one cycle after accepting an accumulate to addr 5 -> addr 5 is unchanged (no clear build) and sat stays 0.

Source files
------------

// File: rtl/synapse_mem.sv
// Signed synapse word store: registered reads plus a two-stage overwrite/saturating-accumulate update path.
// Define SYNAPSE_MEM_CLEAR_EN to build the power-on clear FSM that zeroes every word after reset.
module synapse_mem #(
  parameter int ADDR_W = 4,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic              upd_mode,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DW-1:0]     upd_data,
  output logic              busy,
  output logic              sat
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] SMAX = ~SMIN;

  logic [DW-1:0]     r_mem [DEPTH];
  logic              r_s1_valid;
  logic              r_s1_mode;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DW-1:0]     r_s1_data;
  logic [DW-1:0]     r_s1_old;

  logic [DW:0]       w_sum;
  logic              w_ovf;
  logic [DW-1:0]     w_acc;
  logic [DW-1:0]     w_res;
  logic [DW-1:0]     w_old;
  logic              w_accept;
  logic              w_rd_fire;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  always_comb begin
    w_sum = {r_s1_old[DW-1], r_s1_old}
          + {r_s1_data[DW-1], r_s1_data};
    w_ovf = w_sum[DW] ^ w_sum[DW-1];
    w_acc = w_sum[DW-1:0];
    if (w_ovf) w_acc = w_sum[DW] ? SMIN : SMAX;
    w_res = r_s1_mode ? w_acc : r_s1_data;
  end

  assign upd_ready = ~busy;
  assign w_accept  = upd_valid & upd_ready;
  assign w_rd_fire = rd_en & ~busy;
  // A commit landing on the same edge must feed the next update's old word.
  assign w_old = (r_s1_valid && (r_s1_addr == upd_addr))
               ? w_res : r_mem[upd_addr];

`ifdef SYNAPSE_MEM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign w_clr_we   = (r_state == CLEAR);
  assign w_clr_addr = r_clr_cnt;
`else
  assign busy       = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[w_clr_addr] <= '0;
    else if (r_s1_valid)
      r_mem[r_s1_addr] <= w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      sat        <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s1_old   <= '0;
    end else begin
      rd_valid   <= w_rd_fire;
      if (w_rd_fire) rd_data <= r_mem[rd_addr];
      sat        <= r_s1_valid & r_s1_mode & w_ovf;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode <= upd_mode;
        r_s1_addr <= upd_addr;
        r_s1_data <= upd_data;
        r_s1_old  <= w_old;
      end
    end
  end

endmodule
